// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter with a one-word holding buffer, optional parity
// and one or two stop bits; frame starts are held off while i_rx_busy is high.
module uart_tx_cfg #(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rx_busy,
   input  logic                 i_tx_valid,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx_ready,
   output logic                 o_tx_data,
   output logic                 o_tx_busy,
   output logic                 o_tx_done
);

   localparam int unsigned DIV   = (BAUD_RATE == 0) ? 0 : CLK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

   if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_tx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] buf_data, buf_data_n;
   logic                 buf_full, buf_full_n;
   logic                 par_bit, par_n;
   logic                 line_n;
   logic                 done_n;
   logic                 tick;

   assign tick = (cnt == CNT_W'(DIV - 1));

   // State and datapath registers; ready mirrors the next buffer state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         buf_data   <= '0;
         buf_full   <= 1'b0;
         par_bit    <= 1'b0;
         o_tx_ready <= 1'b0;
         o_tx_data  <= 1'b1;
         o_tx_busy  <= 1'b0;
         o_tx_done  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         buf_data   <= buf_data_n;
         buf_full   <= buf_full_n;
         par_bit    <= par_n;
         o_tx_ready <= ~buf_full_n;
         o_tx_data  <= line_n;
         o_tx_busy  <= (state_n != S_IDLE);
         o_tx_done  <= done_n;
      end
   end

   // Next-state, buffer and line logic
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      shreg_n    = shreg;
      buf_data_n = buf_data;
      buf_full_n = buf_full;
      par_n      = par_bit;
      line_n     = o_tx_data;
      done_n     = 1'b0;

      if (i_tx_valid && o_tx_ready) begin
         buf_full_n = 1'b1;
         buf_data_n = i_tx_data;
      end

      if (state != S_IDLE) begin
         cnt_n = tick ? '0 : cnt + CNT_W'(1);
      end

      case (state)
         S_IDLE: begin
            if (buf_full && !i_rx_busy) begin
               state_n    = S_START;
               cnt_n      = '0;
               idx_n      = '0;
               shreg_n    = buf_data;
               par_n      = (^buf_data) ^ (PARITY == 2);
               buf_full_n = 1'b0;
               line_n     = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               state_n = S_DATA;
               line_n  = shreg[0];
               shreg_n = shreg >> 1;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (idx == IDX_W'(DATA_BITS - 1)) begin
                  idx_n = '0;
                  if (PARITY != 0) begin
                     state_n = S_PARITY;
                     line_n  = par_bit;
                  end else begin
                     state_n = S_STOP;
                     line_n  = 1'b1;
                  end
               end else begin
                  idx_n   = idx + IDX_W'(1);
                  line_n  = shreg[0];
                  shreg_n = shreg >> 1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_n = S_STOP;
               line_n  = 1'b1;
            end
         end
         S_STOP: begin
            // idx counts stop bits here; it was cleared on leaving DATA
            if (tick) begin
               if (idx == IDX_W'(STOP_BITS - 1)) begin
                  state_n = S_IDLE;
                  idx_n   = '0;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four instances (8N1, 7O1, 7E1, 8N2) at DIV=10,
// table vectors, random frames against a frame-building model, and corner sequences.
module tb_uart_tx_cfg;

   localparam int DIV = 10;

   logic       clk;
   logic       rst;
   logic       rx_busy;
   logic [7:0] data;
   logic       valid [4];
   logic       line  [4];
   logic       done  [4];
   logic       ready [4];
   logic       busy  [4];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u_8n1 (.i_clk(clk), .i_reset(rst), .i_rx_busy(rx_busy), .i_tx_valid(valid[0]), .i_tx_data(data),
             .o_tx_ready(ready[0]), .o_tx_data(line[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
   uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
      u_7o1 (.i_clk(clk), .i_reset(rst), .i_rx_busy(1'b0), .i_tx_valid(valid[1]), .i_tx_data(data[6:0]),
             .o_tx_ready(ready[1]), .o_tx_data(line[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
   uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
      u_7e1 (.i_clk(clk), .i_reset(rst), .i_rx_busy(1'b0), .i_tx_valid(valid[2]), .i_tx_data(data[6:0]),
             .o_tx_ready(ready[2]), .o_tx_data(line[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
   uart_tx_cfg #(.CLK_FREQ(100000000), .BAUD_RATE(10000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
      u_8n2 (.i_clk(clk), .i_reset(rst), .i_rx_busy(1'b0), .i_tx_valid(valid[3]), .i_tx_data(data),
             .o_tx_ready(ready[3]), .o_tx_data(line[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));

   typedef struct {
      int          unit;
      logic [7:0]  d;
      logic [15:0] bits;  // bit i = line level during frame bit i (start bit first)
      int          len;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cfg_db(input int u);
      return (u == 1 || u == 2) ? 7 : 8;
   endfunction

   function automatic int cfg_par(input int u);
      return (u == 1) ? 2 : (u == 2) ? 1 : 0;
   endfunction

   function automatic int cfg_sb(input int u);
      return (u == 3) ? 2 : 1;
   endfunction

   // Frame as a list of line levels: start, data LSB first, optional parity, stops
   function automatic logic [15:0] model_frame(input int u, input logic [7:0] d, output int len);
      logic [15:0] f;
      logic        p;
      int          pos;
      f   = '0;
      p   = 1'b0;
      pos = 1;
      for (int i = 0; i < cfg_db(u); i++) begin
         f[pos] = d[i];
         p      = p ^ d[i];
         pos++;
      end
      if (cfg_par(u) != 0) begin
         f[pos] = (cfg_par(u) == 1) ? p : ~p;
         pos++;
      end
      for (int s = 0; s < cfg_sb(u); s++) begin
         f[pos] = 1'b1;
         pos++;
      end
      len = pos;
      return f;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         chk("rst_line", 16'(line[u]), 16'd1);
         chk("rst_ready", 16'(ready[u]), 16'd0);
         chk("rst_busy", 16'(busy[u]), 16'd0);
         chk("rst_done", 16'(done[u]), 16'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 4; u++) chk("post_rst_ready", 16'(ready[u]), 16'd1);
   endtask

   // One isolated frame: accept at edge N, then check every clock through the done pulse
   task automatic send_frame(input int u, input logic [7:0] d, input logic [15:0] bits, input int len);
      int w;
      w = 0;
      while (ready[u] !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) chk("ready_wait", 16'(ready[u]), 16'd1);
      data     = d;
      valid[u] = 1'b1;
      @(negedge clk);
      valid[u] = 1'b0;
      chk("accept_ready", 16'(ready[u]), 16'd0);
      chk("accept_line", 16'(line[u]), 16'd1);
      for (int t = 1; t <= len * DIV; t++) begin
         @(negedge clk);
         if (t == 1) chk("start_ready", 16'(ready[u]), 16'd1);
         chk("frame_line", 16'(line[u]), 16'(bits[(t - 1) / DIV]));
         chk("frame_done", 16'(done[u]), 16'd0);
         chk("frame_busy", 16'(busy[u]), 16'd1);
      end
      @(negedge clk);
      chk("end_done", 16'(done[u]), 16'd1);
      chk("end_line", 16'(line[u]), 16'd1);
      chk("end_busy", 16'(busy[u]), 16'd0);
      @(negedge clk);
      chk("done_pulse_width", 16'(done[u]), 16'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ba, bb;
      int          la, lb, fl;
      int          u;
      logic [7:0]  d;
      logic        el, er, ed, eb;

      vecs[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10};
      vecs[1] = '{0, 8'h00, 16'({1'b1, 8'h00, 1'b0}), 10};
      vecs[2] = '{0, 8'hFF, 16'({1'b1, 8'hFF, 1'b0}), 10};
      vecs[3] = '{1, 8'h55, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10};
      vecs[4] = '{2, 8'h55, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10};
      vecs[5] = '{1, 8'h7F, 16'({1'b1, 1'b0, 7'h7F, 1'b0}), 10};
      vecs[6] = '{2, 8'h01, 16'({1'b1, 1'b1, 7'h01, 1'b0}), 10};
      vecs[7] = '{3, 8'h00, 16'({2'b11, 8'h00, 1'b0}), 11};
      vecs[8] = '{3, 8'h81, 16'({2'b11, 8'h81, 1'b0}), 11};

      rst     = 1'b1;
      rx_busy = 1'b0;
      data    = '0;
      for (int i = 0; i < 4; i++) valid[i] = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      for (int i = 0; i < 9; i++) send_frame(vecs[i].unit, vecs[i].d, vecs[i].bits, vecs[i].len);

      for (int i = 0; i < 24; i++) begin
         u  = int'($urandom_range(0, 3));
         d  = 8'($urandom);
         ba = model_frame(u, d, la);
         send_frame(u, d, ba, la);
      end

      // Back-to-back: 0x22 buffered mid-frame, a later valid while full is ignored
      ba = model_frame(0, 8'h11, la);
      bb = model_frame(0, 8'h22, lb);
      fl = la * DIV;
      @(negedge clk);
      data     = 8'h11;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      for (int t = 1; t <= 2 * fl + 30; t++) begin
         @(negedge clk);
         el = (t <= fl) ? ba[(t - 1) / DIV] :
              (t >= fl + 2 && t <= 2 * fl + 1) ? bb[(t - fl - 2) / DIV] : 1'b1;
         er = (t < 5) || (t >= fl + 2);
         ed = (t == fl + 1) || (t == 2 * fl + 2);
         chk("b2b_line", 16'(line[0]), 16'(el));
         chk("b2b_ready", 16'(ready[0]), 16'(er));
         chk("b2b_done", 16'(done[0]), 16'(ed));
         if (t == 4) begin data = 8'h22; valid[0] = 1'b1; end
         if (t == 5) valid[0] = 1'b0;
         if (t == 40) begin data = 8'h33; valid[0] = 1'b1; end
         if (t == 41) valid[0] = 1'b0;
      end

      // Held off by rx_busy, then released; mid-frame rx_busy has no effect
      ba = model_frame(0, 8'h5A, la);
      fl = la * DIV;
      @(negedge clk);
      rx_busy  = 1'b1;
      data     = 8'h5A;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      for (int t = 1; t <= fl + 10; t++) begin
         @(negedge clk);
         el = (t >= 6 && t < 6 + fl) ? ba[(t - 6) / DIV] : 1'b1;
         eb = (t >= 6 && t < 6 + fl);
         ed = (t == 6 + fl);
         er = (t >= 6);
         chk("rxb_line", 16'(line[0]), 16'(el));
         chk("rxb_busy", 16'(busy[0]), 16'(eb));
         chk("rxb_done", 16'(done[0]), 16'(ed));
         chk("rxb_ready", 16'(ready[0]), 16'(er));
         if (t == 5) rx_busy = 1'b0;
         if (t == 30) rx_busy = 1'b1;
         if (t == 60) rx_busy = 1'b0;
      end

      // Reset during data bit 3 with a second word waiting in the buffer
      ba = model_frame(0, 8'hF0, la);
      @(negedge clk);
      data     = 8'hF0;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      for (int t = 1; t <= 70; t++) begin
         @(negedge clk);
         if (t <= 44) begin
            el = ba[(t - 1) / DIV];
            er = (t < 3);
            eb = 1'b1;
         end else begin
            el = 1'b1;
            er = (t >= 46);
            eb = 1'b0;
         end
         chk("rstmid_line", 16'(line[0]), 16'(el));
         chk("rstmid_ready", 16'(ready[0]), 16'(er));
         chk("rstmid_busy", 16'(busy[0]), 16'(eb));
         chk("rstmid_done", 16'(done[0]), 16'd0);
         if (t == 2) begin data = 8'h0F; valid[0] = 1'b1; end
         if (t == 3) valid[0] = 1'b0;
         if (t == 44) rst = 1'b1;
         if (t == 45) rst = 1'b0;
      end

      ba = model_frame(0, 8'hC3, la);
      send_frame(0, 8'hC3, ba, la);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
